// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for an RV32I subset (load, store, R-type, branch).
// One shared memory port serves instruction fetch and data access; waits are bounded by a timeout.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OPCode,
  input  logic [3:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [3:0] Operation,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADDR = 4'd2;
  localparam logic [3:0] MEMLD   = 4'd3;
  localparam logic [3:0] MEMST   = 4'd4;
  localparam logic [3:0] WBLD    = 4'd5;
  localparam logic [3:0] EXEC_R  = 4'd6;
  localparam logic [3:0] WB_R    = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] TRAP    = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // The trap fires on the edge that would otherwise complete the MEM_TIMEOUT-th wait cycle.
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX   = '1;

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic [6:0]       op_q;
  logic [3:0]       funct_q;
  logic [3:0]       r_op;
  logic             r_legal;
  logic             mem_state;
  logic             timed_out;

  always_comb begin
    r_op    = 4'b0000;
    r_legal = 1'b1;
    case (funct_q)
      4'b0000: r_op = 4'b0010;
      4'b1000: r_op = 4'b0110;
      4'b0111: r_op = 4'b0000;
      4'b0110: r_op = 4'b0001;
      default: r_legal = 1'b0;
    endcase
  end

  assign mem_state = (state_q == FETCH) || (state_q == MEMLD) || (state_q == MEMST);
  assign timed_out = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt >= WAIT_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (mem_ready)      state_d = DECODE;
        else if (timed_out) state_d = TRAP;
      end
      // DECODE sees the live IR; every later state uses the latched copies.
      DECODE: begin
        case (OPCode)
          OP_LOAD, OP_STORE: state_d = MEMADDR;
          OP_RTYPE:          state_d = EXEC_R;
          OP_BRANCH:         state_d = BRANCH;
          default:           state_d = TRAP;
        endcase
      end
      MEMADDR: state_d = (op_q == OP_STORE) ? MEMST : MEMLD;
      MEMLD: begin
        if (mem_ready)      state_d = WBLD;
        else if (timed_out) state_d = TRAP;
      end
      MEMST: begin
        if (mem_ready)      state_d = FETCH;
        else if (timed_out) state_d = TRAP;
      end
      WBLD:    state_d = FETCH;
      EXEC_R:  state_d = r_legal ? WB_R : TRAP;
      WB_R:    state_d = FETCH;
      BRANCH:  state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      wait_cnt <= '0;
      op_q     <= '0;
      funct_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q    <= OPCode;
        funct_q <= Funct;
      end
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready && (wait_cnt != WAIT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the state and gated by reset so nothing escapes while reset is low.
  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Operation  = 4'b0000;
    Branch     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;
    state      = state_q;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      MEMADDR: begin
        ALUSrc    = 1'b1;
        Operation = 4'b0010;
      end
      MEMLD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMST: begin
        mem_req    = 1'b1;
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      WBLD: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
      end
      EXEC_R: Operation = r_op;
      WB_R: begin
        Operation  = r_op;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        Operation  = 4'b0110;
        Branch     = 1'b1;
        PCWrite    = Zero;
        instr_done = 1'b1;
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      mem_req    = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      Operation  = 4'b0000;
      Branch     = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemToReg   = 1'b0;
      ALUSrc     = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      trap       = 1'b0;
      state      = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model queues the expected outputs of every
// cycle, and a negedge process compares the DUT against that queue.
module tb_multicycle_control;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADDR = 4'd2, S_MEMLD = 4'd3;
  localparam logic [3:0] S_MEMST = 4'd4, S_WBLD = 4'd5, S_EXEC_R = 4'd6, S_WB_R = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8, S_TRAP = 4'd9;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, BEQ = 7'b1100011;

  localparam logic [11:0] NONE = 12'h000, REQ = 12'h001, IORD = 12'h002, IRW = 12'h004;
  localparam logic [11:0] PCW = 12'h008, BR = 12'h010, MRD = 12'h020, MWR = 12'h040;
  localparam logic [11:0] M2R = 12'h080, ASRC = 12'h100, RW = 12'h200, DONE = 12'h400;
  localparam logic [11:0] TRP = 12'h800;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] OPCode = '0;
  logic [3:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, IorD, IRWrite, PCWrite, Branch, MemRead, MemWrite;
  logic       MemToReg, ALUSrc, RegWrite, instr_done, trap;
  logic [3:0] Operation, state;
  logic [19:0] dutVec;

  int checks = 0;
  int errors = 0;
  int doneSeen = 0;
  int memWriteSeen = 0;
  int regWriteSeen = 0;
  logic [19:0] expq[$];

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .OPCode(OPCode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .Operation(Operation), .Branch(Branch), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .instr_done(instr_done), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  assign dutVec = {state, Operation, trap, instr_done, RegWrite, ALUSrc, MemToReg,
                   MemWrite, MemRead, Branch, PCWrite, IRWrite, IorD, mem_req};

  function automatic logic [19:0] expVec(input logic [3:0] st, input logic [3:0] op,
                                         input logic [11:0] f);
    return {st, op, f};
  endfunction

  // {legal, ALU control} for an R-type {instr[30], funct3}
  function automatic logic [4:0] aluOp(input logic [3:0] fn);
    case (fn)
      4'b0000: return {1'b1, 4'b0010};
      4'b1000: return {1'b1, 4'b0110};
      4'b0111: return {1'b1, 4'b0000};
      4'b0110: return {1'b1, 4'b0001};
      default: return {1'b0, 4'b0000};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) checkOutput("cycle_outputs", 32'(dutVec), 32'(expq.pop_front()));
    if (instr_done) doneSeen++;
    if (MemWrite) memWriteSeen++;
    if (RegWrite) regWriteSeen++;
  end

  task automatic step(input bit rdy, input logic [19:0] e);
    mem_ready = rdy;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic memWait(input logic [3:0] st, input int waits, inout int cycles,
                         output bit trapped);
    bit rdy;
    trapped = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      rdy = (i == waits);
      if (st == S_FETCH)
        step(rdy, expVec(st, 4'h0, REQ | MRD | (rdy ? (IRW | PCW) : NONE)));
      else if (st == S_MEMLD)
        step(rdy, expVec(st, 4'h0, REQ | MRD | IORD));
      else
        step(rdy, expVec(st, 4'h0, REQ | MWR | IORD | (rdy ? DONE : NONE)));
      cycles++;
      if (!rdy && (i + 1 >= MEM_TIMEOUT)) begin
        trapped = 1'b1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [3:0] fn, input bit z,
                               input int fw, input int mw, output int cycles,
                               output bit trapped);
    logic [4:0] a;
    cycles = 0;
    OPCode = op;
    Funct  = fn;
    Zero   = z;
    memWait(S_FETCH, fw, cycles, trapped);
    if (trapped) return;
    step(1'b1, expVec(S_DECODE, 4'h0, NONE));
    cycles++;
    OPCode = 7'h7F;
    Funct  = ~fn;
    trapped = 1'b1;
    if (op == LW || op == SW) begin
      step(1'b1, expVec(S_MEMADDR, 4'b0010, ASRC));
      cycles++;
      memWait((op == SW) ? S_MEMST : S_MEMLD, mw, cycles, trapped);
      if (!trapped && op == LW) begin
        step(1'b1, expVec(S_WBLD, 4'h0, RW | M2R | DONE));
        cycles++;
      end
    end else if (op == RT) begin
      a = aluOp(fn);
      step(1'b1, expVec(S_EXEC_R, a[3:0], NONE));
      cycles++;
      if (a[4]) begin
        step(1'b0, expVec(S_WB_R, a[3:0], RW | DONE));
        cycles++;
        trapped = 1'b0;
      end
    end else if (op == BEQ) begin
      step(1'b1, expVec(S_BRANCH, 4'b0110, BR | DONE | (z ? PCW : NONE)));
      cycles++;
      trapped = 1'b0;
    end
  endtask

  task automatic applyReset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, 20'h0);
    reset = 1'b1;
  endtask

  task automatic trapAndRecover(input string name);
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), expVec(S_TRAP, 4'h0, TRP));
    checkOutput(name, 32'({state, trap}), 32'({4'd9, 1'b1}));
    applyReset(2);
  endtask

  initial begin
    int cyc;
    bit tr;
    int d0, w0, r0;
    logic [3:0] functs[4] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110};

    #1 reset = 1'b0;
    #1 checkOutput("reset_outputs_zero", 32'(dutVec), 32'h0);
    @(posedge clk);
    #1;
    applyReset(2);

    d0 = doneSeen; r0 = regWriteSeen;
    applyStimulus(LW, 4'h0, 1'b0, 0, 0, cyc, tr);
    checkOutput("lw_cycles", 32'(cyc), 32'd5);
    checkOutput("lw_done_pulses", 32'(doneSeen - d0), 32'd1);
    checkOutput("lw_regwrite_cycles", 32'(regWriteSeen - r0), 32'd1);

    w0 = memWriteSeen; r0 = regWriteSeen;
    applyStimulus(SW, 4'h0, 1'b0, 0, 2, cyc, tr);
    checkOutput("sw_cycles", 32'(cyc), 32'd6);
    checkOutput("sw_memwrite_cycles", 32'(memWriteSeen - w0), 32'd3);
    checkOutput("sw_no_regwrite", 32'(regWriteSeen - r0), 32'd0);

    foreach (functs[i]) begin
      applyStimulus(RT, functs[i], 1'b1, 0, 0, cyc, tr);
      checkOutput("rtype_cycles", 32'(cyc), 32'd4);
    end

    applyStimulus(BEQ, 4'h0, 1'b1, 0, 0, cyc, tr);
    checkOutput("beq_taken_cycles", 32'(cyc), 32'd3);
    applyStimulus(BEQ, 4'h0, 1'b0, 1, 0, cyc, tr);
    checkOutput("beq_not_taken_cycles", 32'(cyc), 32'd4);

    applyStimulus(LW, 4'h0, 1'b0, MEM_TIMEOUT - 1, 3, cyc, tr);
    checkOutput("lw_ready_at_limit_cycles", 32'(cyc), 32'd22);
    checkOutput("lw_ready_at_limit_no_trap", 32'(tr), 32'd0);

    applyStimulus(LW, 4'h0, 1'b0, 0, 40, cyc, tr);
    checkOutput("memld_timeout_cycles", 32'(cyc), 32'd18);
    trapAndRecover("memld_timeout_trap");

    applyStimulus(RT, 4'b0001, 1'b0, 0, 0, cyc, tr);
    checkOutput("bad_funct_cycles", 32'(cyc), 32'd3);
    trapAndRecover("bad_funct_trap");

    applyStimulus(7'b0010011, 4'h0, 1'b0, 0, 0, cyc, tr);
    checkOutput("bad_opcode_cycles", 32'(cyc), 32'd2);
    trapAndRecover("bad_opcode_trap");

    applyStimulus(LW, 4'h0, 1'b0, 100, 0, cyc, tr);
    checkOutput("fetch_timeout_cycles", 32'(cyc), 32'd15);
    trapAndRecover("fetch_timeout_trap");

    // Store stalled in MEMST, then reset asserted mid-cycle while MemWrite is high
    OPCode = SW;
    cyc = 0;
    memWait(S_FETCH, 0, cyc, tr);
    step(1'b1, expVec(S_DECODE, 4'h0, NONE));
    step(1'b0, expVec(S_MEMADDR, 4'b0010, ASRC));
    step(1'b0, expVec(S_MEMST, 4'h0, REQ | MWR | IORD));
    mem_ready = 1'b0;
    #2 checkOutput("memwrite_before_reset", 32'(MemWrite), 32'd1);
    reset = 1'b0;
    #1 checkOutput("async_reset_outputs", 32'(dutVec), 32'h0);
    @(posedge clk);
    #1;
    applyReset(2);

    applyStimulus(LW, 4'h0, 1'b0, 1, 1, cyc, tr);
    checkOutput("lw_after_reset_cycles", 32'(cyc), 32'd7);

    @(negedge clk);
    checkOutput("expect_queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
